out_buf_drain_ctrl: RTL and testbench
=====================================

# out_buf_drain_ctrl

Hardware reader for the compute cluster's output buffers, the consumer side of the `com_unit_out_buf_sel` / `out_buf_dat` read port. After a layer pass completes, it selects each compute unit's output buffer in turn, captures the full buffer word, and streams it out as `BUS_W`-bit beats over a valid/ready interface toward the write-back path. It replaces the bench-driven static buffer select with a sequenced, back-pressurable drain.

## Interface
Parameters:
- COMPUTE_UNIT_NUM, 4, number of compute-unit output buffers; must be ≥ 2.
- OUT_BUF_W, 128, width of `out_buf_dat_i`; must be a multiple of BUS_W.
- BUS_W, 32, width of one output beat.
- RD_LAT, 1, cycles from `com_unit_out_buf_sel_o` change to valid `out_buf_dat_i`; range 0..3.
- Derived: BEATS = OUT_BUF_W/BUS_W; CU_W = $clog2(COMPUTE_UNIT_NUM); BT_W = max(1, $clog2(BEATS)).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- drain_start_i  in  1  one-cycle start pulse; sampled only in IDLE.
- cu_num_i  in  CU_W+1  number of buffers to drain, units 0..cu_num_i-1; sampled with start.
- busy_o  out  1  high from the cycle after start until done.
- done_o  out  1  one-cycle pulse at drain completion.
- com_unit_out_buf_sel_o  out  CU_W  buffer select to the cluster.
- out_buf_dat_i  in  OUT_BUF_W  selected buffer contents.
- out_valid_o  out  1  beat valid.
- out_ready_i  in  1  downstream accept.
- out_dat_o  out  BUS_W  beat data.
- out_cu_idx_o  out  CU_W  source unit of the current beat.
- out_beat_idx_o  out  BT_W  beat index within the unit.
- out_last_o  out  1  final beat of the final unit.

## Operation
- FSM states: IDLE, SEL, WAIT, CAP, SEND, DONE.
- IDLE: on `drain_start_i`, latch `cu_num_i` into `cu_num_r`. If `cu_num_i` = 0, go to DONE. Otherwise set `cu_idx` = 0, drive sel = 0, and go to SEL. A `cu_num_i` value greater than COMPUTE_UNIT_NUM is clamped to COMPUTE_UNIT_NUM.
- SEL: load `lat_cnt` = RD_LAT. Go to CAP if RD_LAT = 0, else go to WAIT.
- WAIT: decrement `lat_cnt`. When it reaches 1, go to CAP.
- CAP: register `out_buf_dat_i` into the `OUT_BUF_W` shadow register. Set `beat` = 0 and go to SEND.
- SEND: `out_dat_o` = shadow[beat*BUS_W +: BUS_W], LSB slice first.
  - On `out_valid_o && out_ready_i`: if beat < BEATS-1, increment beat.
  - Else, if `cu_idx` < `cu_num_r`-1: increment `cu_idx`, update sel, and go to SEL.
  - Else go to DONE.
- DONE: assert `done_o` for one cycle and go to IDLE.
- `out_valid_o` is high only in SEND.
- While `out_ready_i` is low, `out_dat_o`, `out_cu_idx_o`, `out_beat_idx_o` and `out_last_o` are held stable.
- `out_last_o` = SEND && beat = BEATS-1 && `cu_idx` = `cu_num_r`-1.
- `drain_start_i` outside IDLE is ignored; no queuing.
- `com_unit_out_buf_sel_o` holds its last value in IDLE and DONE.
- Because of the shadow register, the cluster buffer may change after CAP without corrupting the beats in flight.

## Timing
- Reset values: state IDLE, `busy_o` 0, `done_o` 0, `com_unit_out_buf_sel_o` 0, `out_valid_o` 0, `out_dat_o` 0, `out_cu_idx_o` 0, `out_beat_idx_o` 0, `out_last_o` 0.
- Reset asserted mid-drain returns to IDLE immediately and drops `out_valid_o` asynchronously; no `done_o` is issued.
- Start sampled at edge E0: sel updated and `busy_o` = 1 after E0. With RD_LAT = 1, capture happens at E0+2 and `out_valid_o` rises after E0+3.
- Per-unit overhead: 2 + RD_LAT cycles (SEL, WAIT×RD_LAT, CAP).
- Full drain with `out_ready_i` tied high: `cu_num_r` × (2 + RD_LAT + BEATS) cycles. `done_o` is high in the cycle after the final handshake.
- `busy_o` deasserts in the same cycle `done_o` is high.
- With `cu_num_i` = 0: `done_o` is high in the cycle after start and `out_valid_o` never rises.

## Test plan
- Defaults, `cu_num_i` = 4, ready always high, each buffer filled with a distinct pattern (e.g. 0x{cu}{beat}A5A5):
  - exactly 16 beats, in CU order 0..3 with beats 0..3 each;
  - beat data equals the correct 32-bit slices;
  - `out_last_o` only on beat 16;
  - `done_o` pulses once, 4×(3+4) = 28 cycles after start.
- Random `out_ready_i` at 30%: same 16 beats, with data and indices stable while ready is low.
- `cu_num_i` = 0: `done_o` one cycle after start, `out_valid_o` never rises. `cu_num_i` = 7: clamped, drains 4 units.
- RD_LAT = 0 and RD_LAT = 3, with `out_buf_dat_i` modeled by a delay line of sel: captured data matches the selected unit; per-unit overhead is 2 and 5 cycles respectively.
- `drain_start_i` pulsed during SEND: ignored, beat sequence unchanged, single `done_o`.
- `rst_i` low during CU 2, beat 1: all outputs return to reset values immediately. A new start then drains from CU 0, beat 0.

Source files
------------

// File: rtl/out_buf_drain_ctrl_if.sv
// Beat stream from the output-buffer drain controller toward the write-back path.
interface out_buf_drain_ctrl_if #(
    parameter int unsigned BUS_W = 32,
    parameter int unsigned CU_W  = 2,
    parameter int unsigned BT_W  = 2
);
    logic              out_valid;
    logic              out_ready;
    logic [BUS_W-1:0]  out_dat;
    logic [CU_W-1:0]   out_cu_idx;
    logic [BT_W-1:0]   out_beat_idx;
    logic              out_last;

    modport master (
        output out_valid, out_dat, out_cu_idx, out_beat_idx, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_dat, out_cu_idx, out_beat_idx, out_last,
        output out_ready
    );
endinterface

// File: rtl/out_buf_drain_ctrl.sv
// Sequenced reader of the compute-unit output buffers: selects each unit, captures
// its full word into a shadow register and streams it out as back-pressurable beats.
module out_buf_drain_ctrl #(
    parameter  int unsigned COMPUTE_UNIT_NUM = 4,
    parameter  int unsigned OUT_BUF_W        = 128,
    parameter  int unsigned BUS_W            = 32,
    parameter  int unsigned RD_LAT           = 1,
    localparam int unsigned BEATS            = OUT_BUF_W / BUS_W,
    localparam int unsigned CU_W             = $clog2(COMPUTE_UNIT_NUM),
    localparam int unsigned BT_W             = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  drain_start_i,
    input  logic [CU_W:0]         cu_num_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CU_W-1:0]       com_unit_out_buf_sel_o,
    input  logic [OUT_BUF_W-1:0]  out_buf_dat_i,
    out_buf_drain_ctrl_if.master  out_bus
);

    localparam int unsigned LAT_W = 2;
    localparam logic [CU_W:0]   CU_MAX    = (CU_W+1)'(COMPUTE_UNIT_NUM);
    localparam logic [BT_W-1:0] BEAT_LAST = BT_W'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, SEL, WAIT, CAP, SEND, DONE} state_t;

    state_t                state_q, state_n;
    logic [CU_W:0]         cu_num_q, cu_num_n;
    logic [CU_W-1:0]       cu_idx_q, cu_idx_n;
    logic [BT_W-1:0]       beat_q, beat_n;
    logic [LAT_W-1:0]      lat_q, lat_n;
    logic [OUT_BUF_W-1:0]  shadow_q, shadow_n;
    logic                  valid_q, valid_n;
    logic                  last_q, last_n;
    logic                  busy_n, done_n;
    logic                  cu_last_c;

    assign cu_last_c = ({1'b0, cu_idx_q} == (cu_num_q - (CU_W+1)'(1)));

    // Next-state and next-output logic
    always_comb begin
        state_n  = state_q;
        cu_num_n = cu_num_q;
        cu_idx_n = cu_idx_q;
        beat_n   = beat_q;
        lat_n    = lat_q;
        shadow_n = shadow_q;

        unique case (state_q)
            IDLE: begin
                if (drain_start_i) begin
                    cu_num_n = (cu_num_i > CU_MAX) ? CU_MAX : cu_num_i;
                    if (cu_num_i == '0) begin
                        state_n = DONE;
                    end else begin
                        cu_idx_n = '0;
                        state_n  = SEL;
                    end
                end
            end
            SEL: begin
                lat_n   = LAT_W'(RD_LAT);
                state_n = (RD_LAT == 0) ? CAP : WAIT;
            end
            WAIT: begin
                lat_n = lat_q - LAT_W'(1);
                if (lat_q <= LAT_W'(1)) begin
                    state_n = CAP;
                end
            end
            CAP: begin
                shadow_n = out_buf_dat_i;
                beat_n   = '0;
                state_n  = SEND;
            end
            SEND: begin
                // Low slice of the shadow is always the current beat; shift on accept
                if (out_bus.out_ready) begin
                    if (beat_q != BEAT_LAST) begin
                        beat_n   = beat_q + BT_W'(1);
                        shadow_n = shadow_q >> BUS_W;
                    end else if (!cu_last_c) begin
                        cu_idx_n = cu_idx_q + CU_W'(1);
                        state_n  = SEL;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n  = (state_n == SEL) || (state_n == WAIT) || (state_n == CAP) || (state_n == SEND);
        done_n  = (state_n == DONE);
        valid_n = (state_n == SEND);
        last_n  = valid_n && (beat_n == BEAT_LAST) &&
                  ({1'b0, cu_idx_n} == (cu_num_n - (CU_W+1)'(1)));
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            cu_num_q <= '0;
            cu_idx_q <= '0;
            beat_q   <= '0;
            lat_q    <= '0;
            shadow_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            state_q  <= state_n;
            cu_num_q <= cu_num_n;
            cu_idx_q <= cu_idx_n;
            beat_q   <= beat_n;
            lat_q    <= lat_n;
            shadow_q <= shadow_n;
            valid_q  <= valid_n;
            last_q   <= last_n;
            busy_o   <= busy_n;
            done_o   <= done_n;
        end
    end

    assign com_unit_out_buf_sel_o = cu_idx_q;
    assign out_bus.out_valid      = valid_q;
    assign out_bus.out_dat        = shadow_q[BUS_W-1:0];
    assign out_bus.out_cu_idx     = cu_idx_q;
    assign out_bus.out_beat_idx   = beat_q;
    assign out_bus.out_last       = last_q;

endmodule

// File: tb/tb_out_buf_drain_ctrl.sv
// Randomized bench for out_buf_drain_ctrl: three read latencies, beat-queue reference model.
module tb_out_buf_drain_ctrl;

    localparam int unsigned CUN       = 4;
    localparam int unsigned OUT_BUF_W = 128;
    localparam int unsigned BUS_W     = 32;
    localparam int unsigned BEATS     = OUT_BUF_W / BUS_W;
    localparam int unsigned CU_W      = 2;
    localparam int unsigned BT_W      = 2;
    localparam int unsigned NI        = 3;

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    endfunction

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NI-1:0]     start;
    logic [CU_W:0]     cu_num;
    logic              ready;
    logic [NI-1:0]     busy, done, valid, last;
    logic [CU_W-1:0]   sel  [NI];
    logic [BUS_W-1:0]  dat  [NI];
    logic [CU_W-1:0]   cidx [NI];
    logic [BT_W-1:0]   bidx [NI];
    logic [OUT_BUF_W-1:0] bufmem [CUN];

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned LAT = lat_of(g);
        out_buf_drain_ctrl_if #(.BUS_W(BUS_W), .CU_W(CU_W), .BT_W(BT_W)) bus ();
        logic [CU_W-1:0]      sd1, sd2, sd3, rsel;
        logic [OUT_BUF_W-1:0] rd_dat;

        // Cluster read port: data follows the select after LAT cycles
        always @(posedge clk) begin
            sd1 <= sel[g];
            sd2 <= sd1;
            sd3 <= sd2;
        end
        always_comb begin
            case (LAT)
                0:       rsel = sel[g];
                1:       rsel = sd1;
                2:       rsel = sd2;
                default: rsel = sd3;
            endcase
        end
        assign rd_dat = bufmem[rsel];

        out_buf_drain_ctrl #(
            .COMPUTE_UNIT_NUM(CUN), .OUT_BUF_W(OUT_BUF_W), .BUS_W(BUS_W), .RD_LAT(LAT)
        ) u_dut (
            .clk_i                  (clk),
            .rst_i                  (rst_n),
            .drain_start_i          (start[g]),
            .cu_num_i               (cu_num),
            .busy_o                 (busy[g]),
            .done_o                 (done[g]),
            .com_unit_out_buf_sel_o (sel[g]),
            .out_buf_dat_i          (rd_dat),
            .out_bus                (bus)
        );

        assign bus.out_ready = ready;
        assign valid[g]      = bus.out_valid;
        assign dat[g]        = bus.out_dat;
        assign cidx[g]       = bus.out_cu_idx;
        assign bidx[g]       = bus.out_beat_idx;
        assign last[g]       = bus.out_last;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] beat_word(input int cu, input int b, input logic lst,
                                              input logic [BUS_W-1:0] d);
        return 64'({CU_W'(cu), BT_W'(b), lst, d});
    endfunction

    function automatic logic [63:0] obs(input int i);
        return 64'({sel[i], busy[i], done[i], valid[i], last[i], cidx[i], bidx[i], dat[i]});
    endfunction

    task automatic fill_bufs();
        for (int cu = 0; cu < CUN; cu++)
            for (int b = 0; b < BEATS; b++)
                bufmem[cu][b*BUS_W +: BUS_W] = {4'(cu), 4'(b), 24'($urandom)};
    endtask

    // Drain n_req units on instance inst; mode 1 = random ready (30% high)
    task automatic run_drain(input int inst, input int n_req, input int mode,
                             input bit poke_start, input bit chk_time);
        int n_eff, lat, done_cnt, done_t, first_v, nbeats, pop_cnt;
        bit pv, pr;
        logic [63:0] held, cur;
        lat   = lat_of(inst);
        n_eff = (n_req > int'(CUN)) ? int'(CUN) : n_req;
        fill_bufs();
        exp_q.delete();
        for (int u = 0; u < n_eff; u++)
            for (int b = 0; b < BEATS; b++)
                exp_q.push_back(beat_word(u, b, (u == n_eff-1) && (b == BEATS-1),
                                          bufmem[u][b*BUS_W +: BUS_W]));
        nbeats = exp_q.size();
        @(negedge clk);
        cu_num = (CU_W+1)'(n_req);
        start[inst] = 1'b1;
        ready = 1'b1;
        done_cnt = 0; done_t = -1; first_v = -1; pop_cnt = 0;
        pv = 1'b0; pr = 1'b0; held = '0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            start[inst] = 1'b0;
            if (t == 0) chk("busy_after_start", 64'(busy[inst]), 64'(n_eff != 0));
            if (done[inst]) begin
                done_cnt++;
                if (done_t < 0) done_t = t;
                chk("busy_with_done", 64'(busy[inst]), 64'(0));
            end
            if (valid[inst] && first_v < 0) first_v = t;
            cur = beat_word(int'(cidx[inst]), int'(bidx[inst]), last[inst], dat[inst]);
            if (pv && !pr) chk("hold_while_stalled", {cur[62:0], valid[inst]}, {held[62:0], 1'b1});
            ready = (mode != 0) ? ($urandom_range(99) < 30) : 1'b1;
            if (poke_start && valid[inst] && pop_cnt == 5) begin
                start[inst] = 1'b1;
                cu_num = (CU_W+1)'(1);
            end
            if (valid[inst] && ready) begin
                if (exp_q.size() == 0) chk("beat_count_overrun", 64'(pop_cnt + 1), 64'(nbeats));
                else chk($sformatf("beat%0d_u%0d", pop_cnt, inst), cur, exp_q.pop_front());
                pop_cnt++;
            end
            pv = valid[inst]; pr = ready; held = cur;
            if (done_t >= 0 && t >= done_t + 3) break;
        end
        chk("done_count", 64'(done_cnt), 64'(1));
        chk("beats_drained", 64'(pop_cnt), 64'(nbeats));
        if (n_eff == 0) chk("no_valid", 64'(first_v), 64'(-1));
        if (chk_time) begin
            chk("done_time", 64'(done_t), 64'(n_eff * (2 + lat + int'(BEATS))));
            if (n_eff > 0) chk("first_valid_time", 64'(first_v), 64'(2 + lat));
        end
    endtask

    task automatic run_reset_mid();
        bit hit;
        fill_bufs();
        @(negedge clk);
        cu_num = (CU_W+1)'(4);
        start[0] = 1'b1;
        ready = 1'b1;
        hit = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            start[0] = 1'b0;
            if (valid[0] && cidx[0] == CU_W'(2) && bidx[0] == BT_W'(1)) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reached_cu2_beat1", 64'(hit), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", obs(0), 64'(0));
        @(negedge clk);
        chk("no_done_in_reset", 64'(done[0]), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", 64'({busy[0], done[0], valid[0]}), 64'(0));
        run_drain(0, 4, 0, 1'b0, 1'b1);
    endtask

    initial begin
        int inst, n, m;
        rst_n = 1'b0;
        start = '0;
        cu_num = '0;
        ready = 1'b0;
        fill_bufs();
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) chk($sformatf("reset_state_u%0d", i), obs(i), 64'(0));
        rst_n = 1'b1;

        run_drain(0, 4, 0, 1'b0, 1'b1);
        run_drain(0, 4, 1, 1'b0, 1'b0);
        run_drain(0, 4, 1, 1'b0, 1'b0);
        run_drain(0, 0, 0, 1'b0, 1'b1);
        run_drain(0, 7, 0, 1'b0, 1'b1);
        run_drain(1, 4, 0, 1'b0, 1'b1);
        run_drain(2, 4, 0, 1'b0, 1'b1);
        run_drain(1, 3, 1, 1'b0, 1'b0);
        run_drain(2, 2, 1, 1'b0, 1'b0);
        run_drain(0, 4, 0, 1'b1, 1'b1);
        run_reset_mid();
        repeat (8) begin
            inst = int'($urandom_range(2));
            n    = int'($urandom_range(7));
            m    = int'($urandom_range(1));
            run_drain(inst, n, m, 1'b0, m == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
